// File: rtl/sprite_line_scheduler_pkg.sv
// Shared constants and FSM encoding for the sprite line scheduler.
package sprite_line_scheduler_pkg;

    localparam int SPRITE_W = 16;
    localparam int SPRITE_H = 16;
    localparam int POS_W    = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sprite_line_scheduler_slot_render.sv
// One slot's column/mirror logic: decides whether this slot lights the
// pixel at the current beam column. The 16-pixel-wide sprite is built
// from an 8-bit row, with the right half being the mirror of the left.
module sprite_slot_render
    import sprite_line_scheduler_pkg::*;
(
    input  logic             valid,
    input  logic [POS_W-1:0] hpos,
    input  logic [POS_W-1:0] slot_x,
    input  logic [7:0]       bits,
    output logic             pixel
);

    logic [POS_W-1:0] col;
    logic             active;

    // Column relative to slot origin wraps mod 512, so sprites straddling
    // the right edge continue at hpos 0.
    always_comb begin
        col    = hpos - slot_x;
        active = valid && (col < POS_W'(SPRITE_W));
        if (!active)
            pixel = 1'b0;
        else if (col[3])
            pixel = bits[~col[2:0]];
        else
            pixel = bits[col[2:0]];
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite fetch: during horizontal blank, scans all candidate
// sprites for the next line, captures up to NUM_SLOTS bitmap rows, then
// renders them with lowest-slot priority while the beam is visible.
module sprite_line_scheduler
    import sprite_line_scheduler_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int NUM_SLOTS   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [8:0]                   hpos,
    input  logic [8:0]                   vpos,
    input  logic                         hsync,
    input  logic                         display_on,
    input  logic [NUM_SPRITES-1:0]       sprite_en,
    input  logic [9*NUM_SPRITES-1:0]     sprite_x,
    input  logic [9*NUM_SPRITES-1:0]     sprite_y,
    output logic [3:0]                   rom_yofs,
    input  logic [7:0]                   rom_bits,
    output logic                         gfx,
    output logic [2:0]                   gfx_id,
    output logic                         overflow,
    output logic                         busy
);

    state_t           state_reg;
    logic             hsync_reg;
    logic             edge_reg;
    logic [2:0]       scan_idx_reg;
    logic [POS_W-1:0] target_reg;
    logic [3:0]       fill_reg;
    logic             overflow_reg;
    logic             busy_reg;
    logic             gfx_reg;
    logic [2:0]       gfx_id_reg;

    logic             slot_valid_reg [NUM_SLOTS];
    logic [7:0]       slot_bits_reg  [NUM_SLOTS];
    logic [POS_W-1:0] slot_x_reg     [NUM_SLOTS];
    logic [2:0]       slot_id_reg    [NUM_SLOTS];
    logic             slot_pix       [NUM_SLOTS];

    logic [POS_W-1:0] spr_x [NUM_SPRITES];
    logic [POS_W-1:0] spr_y [NUM_SPRITES];

    logic [POS_W-1:0] scan_d;
    logic             scan_hit;
    logic             win_found;
    logic [2:0]       win_id;

    genvar gi;

    // Unpack the flat position buses into per-sprite arrays.
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_unpack
            assign spr_x[gi] = sprite_x[POS_W*gi +: POS_W];
            assign spr_y[gi] = sprite_y[POS_W*gi +: POS_W];
        end
    endgenerate

    // Vertical hit test for the sprite under evaluation; the ROM row is
    // addressed bottom-up, so row index is 15 - d.
    always_comb begin
        scan_d   = target_reg - spr_y[scan_idx_reg];
        scan_hit = (state_reg == ST_SCAN) && sprite_en[scan_idx_reg]
                   && (scan_d < POS_W'(SPRITE_H));
        rom_yofs = scan_hit ? (4'(SPRITE_H - 1) - scan_d[3:0]) : 4'd0;
    end

    // Fetch FSM: edge detect, slot clearing, per-sprite scan and slot fill.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            hsync_reg    <= 1'b0;
            edge_reg     <= 1'b0;
            scan_idx_reg <= '0;
            target_reg   <= '0;
            fill_reg     <= '0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_valid_reg[s] <= 1'b0;
                slot_bits_reg[s]  <= '0;
                slot_x_reg[s]     <= '0;
                slot_id_reg[s]    <= '0;
            end
        end else begin
            hsync_reg <= hsync;
            edge_reg  <= hsync & ~hsync_reg;
            case (state_reg)
                ST_IDLE: begin
                    // Edges seen while a fetch runs never reach here.
                    if (edge_reg) begin
                        state_reg  <= ST_CLEAR;
                        target_reg <= vpos + 9'd1;
                        busy_reg   <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    for (int s = 0; s < NUM_SLOTS; s++)
                        slot_valid_reg[s] <= 1'b0;
                    fill_reg     <= '0;
                    overflow_reg <= 1'b0;
                    scan_idx_reg <= '0;
                    state_reg    <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (scan_hit) begin
                        if (fill_reg < 4'(NUM_SLOTS)) begin
                            for (int s = 0; s < NUM_SLOTS; s++) begin
                                if (fill_reg == 4'(s)) begin
                                    slot_valid_reg[s] <= 1'b1;
                                    slot_bits_reg[s]  <= rom_bits;
                                    slot_x_reg[s]     <= spr_x[scan_idx_reg];
                                    slot_id_reg[s]    <= scan_idx_reg;
                                end
                            end
                            fill_reg <= fill_reg + 4'd1;
                        end else begin
                            overflow_reg <= 1'b1;
                        end
                    end
                    if (scan_idx_reg == 3'(NUM_SPRITES - 1))
                        state_reg <= ST_DONE;
                    else
                        scan_idx_reg <= scan_idx_reg + 3'd1;
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // One render unit per slot.
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            sprite_slot_render u_render (
                .valid  (slot_valid_reg[gi]),
                .hpos   (hpos),
                .slot_x (slot_x_reg[gi]),
                .bits   (slot_bits_reg[gi]),
                .pixel  (slot_pix[gi])
            );
        end
    endgenerate

    // Priority select: scanning from the top down leaves the lowest slot.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (slot_pix[s]) begin
                win_found = 1'b1;
                win_id    = slot_id_reg[s];
            end
        end
    end

    // Registered pixel output, one cycle behind hpos.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gfx_reg    <= 1'b0;
            gfx_id_reg <= 3'd0;
        end else begin
            gfx_reg    <= display_on && win_found;
            gfx_id_reg <= (display_on && win_found) ? win_id : 3'd0;
        end
    end

    assign gfx      = gfx_reg;
    assign gfx_id   = gfx_id_reg;
    assign overflow = overflow_reg;
    assign busy     = busy_reg;

endmodule
